audio_mode_ctrl: RTL and testbench
==================================

# audio_mode_ctrl

Sequences the DAC playback source of the voice loop: debounces the user key, cycles the active processing mode (bypass loop, echo cancelling, voice change, mute), and performs click-free switching. Each switch ramps the output gain down, changes source, then ramps back up, one gain step per LRCK frame. It sits between the three processed sample streams and the I2S transmitter's ldata/rdata input, in the 12.288 MHz MCLK domain, gated by codec configuration completion.

## Interface

Parameters:
- DATA_WIDTH, 16, sample width (signed two's complement)
- DEBOUNCE_CYCLES, 245760, clk_12M cycles a key level must be stable (20 ms)
- FADE_SHIFT, 5, log2 of fade steps; FADE_STEPS = 2^FADE_SHIFT frames per ramp

Ports:
- clk_12M  in  1  sole clock, 12.288 MHz
- rstn  in  1  synchronous, active-low reset
- init_done  in  1  high when both codecs are configured
- key  in  1  raw push-button, active-low, asynchronous
- lrck  in  1  DAC frame clock (es1_dlrc), asynchronous to clk_12M
- bypass_data  in  DATA_WIDTH  mode-0 source
- echo_data  in  DATA_WIDTH  mode-1 source
- vchg_data  in  DATA_WIDTH  mode-2 source
- data_out  out  DATA_WIDTH  gain-scaled selected sample to I2S tx
- mode  out  2  active mode: 0 bypass, 1 echo, 2 voice change, 3 mute
- busy  out  1  high whenever state is not RUN

## Operation

- Key path: key is double-flop synchronised. A counter runs while the synced level differs from the debounced level and clears when they match. When the counter reaches DEBOUNCE_CYCLES-1, the debounced level takes the synced value and the counter clears. A press event is a 1-cycle pulse on a debounced 1->0 transition.
- Frame tick: lrck is double-flop synchronised. The tick is a 1-cycle pulse on the synced rising edge.
- Gain: unsigned FADE_SHIFT+1 bits, range 0..FADE_STEPS.
- Source mux by mode: bypass_data, echo_data, vchg_data, or constant 0 (mode 3).
- Output arithmetic: product = signed sample × {0,gain}, width DATA_WIDTH+FADE_SHIFT+2. data_out = product >>> FADE_SHIFT (arithmetic shift, truncation toward −inf). This gives exact pass-through at gain = FADE_STEPS.
- Pending flag: a press event seen in any state other than WAIT_INIT sets pending. A press seen while pending is already set is discarded, so at most one press is queued.
- State machine:
  - WAIT_INIT (reset state): gain = 0. Goes to FADE_IN when init_done = 1.
  - FADE_IN: gain += 1 per tick. Goes to RUN on the tick that makes gain = FADE_STEPS.
  - RUN: goes to FADE_OUT when pending = 1; pending clears on that transition.
  - FADE_OUT: gain −= 1 per tick. Goes to SWITCH on the tick that makes gain = 0.
  - SWITCH: lasts 1 cycle. mode ← mode + 1 (wraps 3→0). Then goes to FADE_IN.
- init_done = 0 in any state: go to WAIT_INIT next cycle, gain ← 0, pending ← 0. mode is retained.

## Timing

- Reset values: data_out = 0, mode = 0, busy = 1, gain = 0, pending = 0, state = WAIT_INIT. All debounce and sync flops take their idle value of 1.
- Data latency: data_out is registered, 1 clk_12M cycle after the data inputs, mode and gain.
- Ticks are counted from the lrck edge: a rising edge produces its tick 3 clk_12M cycles later (2 sync stages plus the edge register). Gain changes on the cycle after the tick.
- Full switch from RUN: 2·FADE_STEPS frame ticks plus 1 cycle (SWITCH), plus the cycle to enter FADE_OUT.
- A press queued during FADE_OUT, SWITCH or FADE_IN starts a new FADE_OUT on the cycle after RUN is entered. busy stays 0 for exactly 1 cycle in that case.
- A press and init_done falling in the same cycle: the press is discarded.
- Ticks in SWITCH and WAIT_INIT are ignored.
- Gain never wraps: it saturates at 0 and FADE_STEPS.

## Test plan

Bench parameters: DEBOUNCE_CYCLES = 16, FADE_SHIFT = 2. lrck period is 256 clk_12M cycles. The three sources are held at +1000, −2000 and +3000.

- Reset, then init_done = 1: data_out steps 0 → 250 → 500 → 750 → 1000, one step per tick. busy falls after the 4th tick. mode = 0.
- key low for 10 cycles (glitch): no press event, mode stays 0, busy stays 0.
- key low for 40 cycles in RUN: data_out ramps down 750/500/250/0, mode becomes 1 (1 cycle in SWITCH), then data_out ramps −500/−1000/−1500/−2000.
- Signed truncation: echo source = −3 at gain 1 -> data_out = −1. bypass source = −32768 at gain 4 -> data_out = −32768.
- Three valid presses during one FADE_OUT: exactly one further switch (mode 1→2→3). data_out = 0 throughout mode 3. Then one more press wraps mode to 0.
- Drop init_done mid-FADE_IN at gain 2: next cycle gain = 0, data_out = 0, busy = 1, mode retained. Re-assert init_done -> soft-start ramp in the retained mode.

Source files
------------

// File: rtl/audio_mode_ctrl.sv
// audio_mode_ctrl
//   Selects the DAC playback source for the voice loop and performs click-free
//   mode switching. A debounced key press queues a switch; each switch ramps
//   gain down one step per LRCK frame, advances the mode, then ramps back up.
//
// Ports
//   clk_12M      sole clock (12.288 MHz MCLK domain)
//   rstn         synchronous active-low reset
//   init_done    codecs configured; low forces a soft restart, mode kept
//   key          raw active-low push-button (asynchronous)
//   lrck         DAC frame clock (asynchronous), rising edge = one gain step
//   bypass_data  mode 0 source
//   echo_data    mode 1 source
//   vchg_data    mode 2 source
//   data_out     registered, gain-scaled selected sample
//   mode         0 bypass, 1 echo, 2 voice change, 3 mute
//   busy         high whenever not in RUN
module audio_mode_ctrl #(
    parameter int DATA_WIDTH      = 16,
    parameter int DEBOUNCE_CYCLES = 245760,
    parameter int FADE_SHIFT      = 5
) (
    input  logic                  clk_12M,
    input  logic                  rstn,
    input  logic                  init_done,
    input  logic                  key,
    input  logic                  lrck,
    input  logic [DATA_WIDTH-1:0] bypass_data,
    input  logic [DATA_WIDTH-1:0] echo_data,
    input  logic [DATA_WIDTH-1:0] vchg_data,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [1:0]            mode,
    output logic                  busy
);

    localparam int FADE_STEPS = 1 << FADE_SHIFT;
    localparam int GW         = FADE_SHIFT + 1;
    localparam int PW         = DATA_WIDTH + FADE_SHIFT + 2;
    localparam int CW         = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    typedef enum logic [2:0] {
        ST_WAIT_INIT,
        ST_FADE_IN,
        ST_RUN,
        ST_FADE_OUT,
        ST_SWITCH
    } state_t;

    // ------------------------------------------------------------------
    // Key synchroniser and debouncer
    // ------------------------------------------------------------------
    logic          r_key_s1, r_key_s2;
    logic          r_key_db, r_key_db_d;
    logic [CW-1:0] r_db_cnt;
    logic          w_press;

    always_ff @(posedge clk_12M) begin
        if (!rstn) begin
            r_key_s1   <= 1'b1;
            r_key_s2   <= 1'b1;
            r_key_db   <= 1'b1;
            r_key_db_d <= 1'b1;
            r_db_cnt   <= '0;
        end else begin
            r_key_s1   <= key;
            r_key_s2   <= r_key_s1;
            r_key_db_d <= r_key_db;
            if (r_key_s2 == r_key_db) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                r_key_db <= r_key_s2;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    // Press = debounced level falling (key is active-low)
    assign w_press = r_key_db_d & ~r_key_db;

    // ------------------------------------------------------------------
    // LRCK synchroniser and frame tick (registered edge detect)
    // ------------------------------------------------------------------
    logic r_lrck_s1, r_lrck_s2, r_lrck_d, r_tick;

    always_ff @(posedge clk_12M) begin
        if (!rstn) begin
            r_lrck_s1 <= 1'b1;
            r_lrck_s2 <= 1'b1;
            r_lrck_d  <= 1'b1;
            r_tick    <= 1'b0;
        end else begin
            r_lrck_s1 <= lrck;
            r_lrck_s2 <= r_lrck_s1;
            r_lrck_d  <= r_lrck_s2;
            r_tick    <= r_lrck_s2 & ~r_lrck_d;
        end
    end

    // ------------------------------------------------------------------
    // Mode / gain sequencer
    // ------------------------------------------------------------------
    state_t        r_state;
    logic [GW-1:0] r_gain;
    logic [1:0]    r_mode;
    logic          r_pending;

    always_ff @(posedge clk_12M) begin
        if (!rstn) begin
            r_state   <= ST_WAIT_INIT;
            r_gain    <= '0;
            r_mode    <= 2'd0;
            r_pending <= 1'b0;
        end else if (!init_done) begin
            // Losing codec config drops any queued press; mode survives
            r_state   <= ST_WAIT_INIT;
            r_gain    <= '0;
            r_pending <= 1'b0;
        end else begin
            if (w_press && r_state != ST_WAIT_INIT)
                r_pending <= 1'b1;
            case (r_state)
                ST_WAIT_INIT: begin
                    r_gain  <= '0;
                    r_state <= ST_FADE_IN;
                end
                ST_FADE_IN: begin
                    if (r_tick && r_gain != GW'(FADE_STEPS)) begin
                        r_gain <= r_gain + 1'b1;
                        if (r_gain == GW'(FADE_STEPS - 1))
                            r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (r_pending) begin
                        // Clear wins over a same-cycle press: only one queued
                        r_pending <= 1'b0;
                        r_state   <= ST_FADE_OUT;
                    end
                end
                ST_FADE_OUT: begin
                    if (r_tick && r_gain != '0) begin
                        r_gain <= r_gain - 1'b1;
                        if (r_gain == GW'(1))
                            r_state <= ST_SWITCH;
                    end
                end
                ST_SWITCH: begin
                    r_mode  <= r_mode + 2'd1;
                    r_state <= ST_FADE_IN;
                end
                default: r_state <= ST_WAIT_INIT;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Source select and gain scaling
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] w_src;
    logic signed [PW-1:0]  w_src_ext;
    logic signed [PW-1:0]  w_gain_ext;
    logic signed [PW-1:0]  w_prod;
    logic [DATA_WIDTH-1:0] r_data_out;

    always_comb begin
        w_src = '0;
        case (r_mode)
            2'd0:    w_src = bypass_data;
            2'd1:    w_src = echo_data;
            2'd2:    w_src = vchg_data;
            default: w_src = '0;
        endcase
    end

    assign w_src_ext  = {{(FADE_SHIFT + 2){w_src[DATA_WIDTH-1]}}, w_src};
    assign w_gain_ext = {{(DATA_WIDTH + 1){1'b0}}, r_gain};
    assign w_prod     = w_src_ext * w_gain_ext;

    // Arithmetic shift floors toward -inf; gain = FADE_STEPS is exact pass-through
    always_ff @(posedge clk_12M) begin
        if (!rstn)
            r_data_out <= '0;
        else
            r_data_out <= DATA_WIDTH'(w_prod >>> FADE_SHIFT);
    end

    assign data_out = r_data_out;
    assign mode     = r_mode;
    assign busy     = (r_state != ST_RUN);

endmodule

// File: tb/tb_audio_mode_ctrl.sv
module tb_audio_mode_ctrl;

  logic        clk_12M = 1'b0;
  logic        rstn;
  logic        init_done;
  logic        key;
  logic        lrck;
  logic [15:0] bypass_data, echo_data, vchg_data;
  logic [15:0] data_out;
  logic [1:0]  mode;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;
  int last_do;
  int busy_lo;

  audio_mode_ctrl #(
    .DATA_WIDTH(16), .DEBOUNCE_CYCLES(16), .FADE_SHIFT(2)
  ) dut (
    .clk_12M(clk_12M), .rstn(rstn), .init_done(init_done), .key(key), .lrck(lrck),
    .bypass_data(bypass_data), .echo_data(echo_data), .vchg_data(vchg_data),
    .data_out(data_out), .mode(mode), .busy(busy)
  );

  always #5 clk_12M = ~clk_12M;

  // 256-cycle frame, phase offset from the clock edges
  initial begin
    lrck = 1'b1;
    #7;
    forever #1280 lrck = ~lrck;
  end

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  // Wait (bounded) for data_out to move off its last value, then check it
  task automatic expect_next(input string tag, input int exp, input int max_cyc);
    int n;
    int v;
    n = 0;
    busy_lo = 0;
    v = int'($signed(data_out));
    while (v == last_do && n < max_cyc) begin
      @(negedge clk_12M);
      n++;
      v = int'($signed(data_out));
      if (!busy) busy_lo++;
    end
    chk(tag, v, exp);
    last_do = exp;
  endtask

  task automatic press(input int low_cyc);
    key = 1'b0;
    repeat (low_cyc) @(negedge clk_12M);
    key = 1'b1;
    repeat (40) @(negedge clk_12M);
  endtask

  initial begin
    int cnt;
    rstn        = 1'b0;
    init_done   = 1'b0;
    key         = 1'b1;
    bypass_data = 16'd1000;
    echo_data   = 16'(-2000);
    vchg_data   = 16'd3000;
    repeat (5) @(negedge clk_12M);
    chk("rst_data", int'($signed(data_out)), 0);
    chk("rst_mode", int'(mode), 0);
    chk("rst_busy", int'(busy), 1);

    // Soft start in bypass
    rstn = 1'b1;
    init_done = 1'b1;
    last_do = 0;
    expect_next("up0_1", 250, 600);
    chk("up0_busy", int'(busy), 1);
    expect_next("up0_2", 500, 400);
    expect_next("up0_3", 750, 400);
    expect_next("up0_4", 1000, 400);
    chk("run0_busy", int'(busy), 0);
    chk("run0_mode", int'(mode), 0);

    // Short glitch must not register
    key = 1'b0;
    repeat (10) @(negedge clk_12M);
    key = 1'b1;
    cnt = 0;
    repeat (100) begin
      @(negedge clk_12M);
      if (busy) cnt++;
    end
    chk("glitch_busy_cycles", cnt, 0);
    chk("glitch_mode", int'(mode), 0);

    // Valid press: bypass -> echo
    press(40);
    expect_next("dn0_3", 750, 400);
    expect_next("dn0_2", 500, 400);
    expect_next("dn0_1", 250, 400);
    expect_next("dn0_0", 0, 400);
    chk("sw1_mode", int'(mode), 1);
    expect_next("up1_1", -500, 400);
    expect_next("up1_2", -1000, 400);
    expect_next("up1_3", -1500, 400);
    expect_next("up1_4", -2000, 400);
    chk("run1_mode", int'(mode), 1);
    chk("run1_busy", int'(busy), 0);

    // Three presses in one fade-out: one more switch is queued, not two
    press(40);
    expect_next("dn1_3", -1500, 400);
    expect_next("dn1_2", -1000, 400);
    press(40);
    press(40);
    expect_next("dn1_1", -500, 400);
    echo_data = 16'(-3);
    repeat (2) @(negedge clk_12M);
    chk("trunc_neg3_g1", int'($signed(data_out)), -1);
    echo_data = 16'(-2000);
    repeat (2) @(negedge clk_12M);
    last_do = -500;
    expect_next("dn1_0", 0, 400);
    chk("sw2_mode", int'(mode), 2);
    expect_next("up2_1", 750, 400);
    expect_next("up2_2", 1500, 400);
    expect_next("up2_3", 2250, 400);
    expect_next("up2_4", 3000, 400);
    chk("queued_busy_lo_cycles", busy_lo, 1);
    chk("queued_busy", int'(busy), 1);
    expect_next("dn2_3", 2250, 400);
    expect_next("dn2_2", 1500, 400);
    expect_next("dn2_1", 750, 400);
    expect_next("dn2_0", 0, 400);

    // Mute: output stays 0 through fade-in and into RUN
    cnt = 0;
    repeat (1400) begin
      @(negedge clk_12M);
      if (data_out != 16'd0) cnt++;
    end
    chk("mute_nonzero_cycles", cnt, 0);
    chk("mute_mode", int'(mode), 3);
    chk("mute_busy", int'(busy), 0);

    // Wrap 3 -> 0
    press(40);
    expect_next("up0b_1", 250, 2000);
    chk("wrap_mode", int'(mode), 0);
    expect_next("up0b_2", 500, 400);
    expect_next("up0b_3", 750, 400);
    expect_next("up0b_4", 1000, 400);
    bypass_data = 16'h8000;
    repeat (2) @(negedge clk_12M);
    chk("trunc_min_g4", int'($signed(data_out)), -32768);
    bypass_data = 16'd1000;
    repeat (2) @(negedge clk_12M);
    last_do = 1000;

    // Switch to echo, then drop init_done mid fade-in at gain 2
    press(40);
    expect_next("dn0b_3", 750, 400);
    expect_next("dn0b_2", 500, 400);
    expect_next("dn0b_1", 250, 400);
    expect_next("dn0b_0", 0, 400);
    expect_next("up1b_1", -500, 400);
    expect_next("up1b_2", -1000, 400);
    init_done = 1'b0;
    repeat (2) @(negedge clk_12M);
    chk("drop_data", int'($signed(data_out)), 0);
    chk("drop_busy", int'(busy), 1);
    chk("drop_mode", int'(mode), 1);
    repeat (600) @(negedge clk_12M);
    chk("drop_hold_data", int'($signed(data_out)), 0);
    init_done = 1'b1;
    last_do = 0;
    expect_next("re_1", -500, 600);
    expect_next("re_2", -1000, 400);
    expect_next("re_3", -1500, 400);
    expect_next("re_4", -2000, 400);
    chk("re_mode", int'(mode), 1);
    chk("re_busy", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
